cnt_bcd_fnd_drv: RTL and testbench
==================================

Name: cnt_bcd_fnd_drv

Overview:
- Downstream consumer of the 0-100 counter stage: takes its binary count and displays it on a 3-digit common-anode 7-segment (FND) module.
- Sequential shift-add-3 (double-dabble) converter turns the count into 3 BCD digits under a valid/ready handshake.
- Refresh scanner time-multiplexes the digits, with leading-zero blanking.

Parameters:
- IN_W, 7, binary input width; legal range 4..9. The upper limit keeps the maximum value below 1000 (3 digits).
- REFRESH_CNT, 50000, clk cycles each digit stays selected; minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_cnt  input  IN_W  binary count to display.
- i_valid  input  1  i_cnt is valid this cycle.
- o_ready  output  1  converter idle; i_cnt is accepted on an edge where i_valid=1 and o_ready=1.
- o_done  output  1  one-cycle pulse: o_bcd just updated.
- o_bcd  output  12  {hundreds, tens, ones}, 4 bits each.
- o_fnd_com  output  3  digit select, one-hot active-low; bit0=ones, bit1=tens, bit2=hundreds.
- o_fnd_seg  output  7  segments, active-low; bit0=a .. bit6=g.

Behaviour:
Reset values:
- o_ready=1, o_done=0, o_bcd=12'h000.
- FSM=IDLE, scan index=0, refresh counter=0.
- o_fnd_com=3'b110, o_fnd_seg=7'h40 (ones digit shows '0').

FSM states: IDLE, SHIFT, DONE.
- IDLE: o_ready=1. At an accept edge E0, capture i_cnt into the shift register, clear the BCD scratch, load bit counter=IN_W, go to SHIFT, o_ready<=0.
- SHIFT: each edge, add 3 to every scratch BCD nibble >=5, then shift {bcd,bin} left by 1 and decrement the counter. This covers edges E1..E(IN_W). After the last shift, go to DONE.
- DONE: at edge E(IN_W+1), o_bcd<=scratch, o_done<=1, o_ready<=1, go to IDLE. o_done clears on the next edge.

Timing:
- Latency: o_done is high in the cycle following edge E(IN_W+1). For IN_W=7, that is 8 edges after acceptance.
- Minimum accept-to-accept spacing: IN_W+2 cycles.
- o_bcd holds its value between conversions; it changes only on the o_done edge.

Boundary conditions:
- i_valid while o_ready=0: ignored, no capture, no queuing.
- i_valid high on the DONE edge: not accepted there (o_ready was 0). It is accepted on the next edge if still high.
- i_valid held high continuously: back-to-back conversions every IN_W+2 cycles.
- Reset mid-conversion: immediate abort, FSM=IDLE, all reset values apply, no o_done.

Scanner (free-running, independent of the FSM):
- Refresh counter counts 0..REFRESH_CNT-1 and wraps.
- On wrap, the scan index advances 0->1->2->0.
- o_fnd_com is driven from the scan index; o_fnd_seg is the decode of the selected o_bcd nibble. Both are combinational from registers, glitch-free per cycle.

Segment codes (gfedcba, active-low):
- 0=40, 1=79, 2=24, 3=30, 4=19
- 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
- Nibble >9: 7'h7F (blank). Unreachable in normal operation.

Leading-zero blanking:
- Hundreds blank (7'h7F) when 0.
- Tens blank when hundreds=0 and tens=0.
- Ones always shown.

Test Plan:
- Reset: assert reset mid-run -> o_bcd=12'h000, o_done=0, o_ready=1, o_fnd_com=3'b110, o_fnd_seg=7'h40, all asynchronously (before the next clk edge).
- Convert 100: i_cnt=100 with one-cycle i_valid -> o_ready low for 8 cycles; o_done single pulse 8 edges after acceptance; o_bcd=12'h100.
- Values 0, 99, 127 in sequence with i_valid held high -> o_bcd 12'h000, 12'h099, 12'h127 in order; accepts exactly 9 cycles apart.
- Busy ignore: accept 55, then i_valid with i_cnt=77 two cycles later -> o_bcd=12'h055, exactly one o_done. 77 is only accepted if i_valid is still high once o_ready returns.
- Scan/blanking: REFRESH_CNT=4, o_bcd=12'h042:
  - o_fnd_com=110, seg 7'h24
  - then o_fnd_com=101, seg 7'h19
  - then o_fnd_com=011, seg 7'h7F
  - each held 4 cycles, repeating.
- Reset mid-conversion: reset at E3 of converting 88 -> no o_done, o_bcd=0. After release, converting 88 -> 12'h088.

Source files
------------

// File: rtl/cnt_bcd_fnd_drv.sv
// cnt_bcd_fnd_drv: sequential double-dabble binary-to-BCD converter driving a multiplexed 3-digit common-anode FND
module cnt_bcd_fnd_drv #(
  parameter int IN_W        = 7,
  parameter int REFRESH_CNT = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] i_cnt,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_done,
  output logic [11:0]     o_bcd,
  output logic [2:0]      o_fnd_com,
  output logic [6:0]      o_fnd_seg
);
  localparam int RC_W = $clog2(REFRESH_CNT);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t          state;
  logic [IN_W-1:0] bin;
  logic [11:0]     bcd;
  logic [11:0]     bcd_adj;
  logic [3:0]      bit_cnt;
  logic [RC_W-1:0] ref_cnt;
  logic            wrap;
  logic [1:0]      scan_idx;
  logic [3:0]      nib;
  logic            blank;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction

  assign bcd_adj = {adj3(bcd[11:8]), adj3(bcd[7:4]), adj3(bcd[3:0])};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bin     <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      o_ready <= 1'b1;
      o_done  <= 1'b0;
      o_bcd   <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_valid) begin
          bin     <= i_cnt;
          bcd     <= '0;
          bit_cnt <= 4'(IN_W);
          o_ready <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
          bit_cnt    <= bit_cnt - 4'd1;
          if (bit_cnt == 4'd1)
            state <= DONE;
        end
        DONE: begin
          o_bcd   <= bcd;
          o_done  <= 1'b1;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wrap = ref_cnt == RC_W'(REFRESH_CNT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt  <= '0;
      scan_idx <= '0;
    end else begin
      ref_cnt <= wrap ? '0 : ref_cnt + RC_W'(1);
      if (wrap)
        scan_idx <= scan_idx == 2'd2 ? 2'd0 : scan_idx + 2'd1;
    end
  end

  assign o_fnd_com = scan_idx == 2'd2 ? 3'b011 : scan_idx == 2'd1 ? 3'b101 : 3'b110;
  assign nib       = scan_idx == 2'd2 ? o_bcd[11:8] : scan_idx == 2'd1 ? o_bcd[7:4] : o_bcd[3:0];
  assign blank     = (scan_idx == 2'd2 && o_bcd[11:8] == 4'd0) || (scan_idx == 2'd1 && o_bcd[11:4] == 8'd0);

  always_comb begin
    o_fnd_seg = 7'h7F;
    if (!blank)
      case (nib)
        4'd0:    o_fnd_seg = 7'h40;
        4'd1:    o_fnd_seg = 7'h79;
        4'd2:    o_fnd_seg = 7'h24;
        4'd3:    o_fnd_seg = 7'h30;
        4'd4:    o_fnd_seg = 7'h19;
        4'd5:    o_fnd_seg = 7'h12;
        4'd6:    o_fnd_seg = 7'h02;
        4'd7:    o_fnd_seg = 7'h78;
        4'd8:    o_fnd_seg = 7'h00;
        4'd9:    o_fnd_seg = 7'h10;
        default: o_fnd_seg = 7'h7F;
      endcase
  end
endmodule

// File: tb/tb_cnt_bcd_fnd_drv.sv
// tb_cnt_bcd_fnd_drv: scoreboard bench for the BCD converter handshake, timing, scanner and blanking
module tb_cnt_bcd_fnd_drv;
  localparam int IN_W = 7;
  typedef struct {logic [11:0] bcd; int acc;} item_t;
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [IN_W-1:0] i_cnt = '0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic            o_done;
  logic [11:0]     o_bcd;
  logic [2:0]      o_fnd_com;
  logic [6:0]      o_fnd_seg;
  int              total = 0;
  int              bad = 0;
  int              n_done = 0;
  int              cyc = 0;
  int              last_acc = -1;
  bit              chk_sp = 1'b0;
  logic [11:0]     exp_cur = '0;
  item_t           sb_q[$];

  cnt_bcd_fnd_drv #(.IN_W(IN_W), .REFRESH_CNT(4)) dut (
    .clk(clk),
    .reset(reset),
    .i_cnt(i_cnt),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_done(o_done),
    .o_bcd(o_bcd),
    .o_fnd_com(o_fnd_com),
    .o_fnd_seg(o_fnd_seg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (!reset && i_valid && o_ready) begin
      sb_q.push_back('{exp_cur, cyc});
      if (chk_sp && last_acc >= 0)
        chk("accept_spacing", cyc - last_acc, IN_W + 2);
      last_acc <= cyc;
    end
  end

  always @(negedge clk) begin
    if (!reset && o_done) begin
      item_t it;
      n_done <= n_done + 1;
      if (sb_q.size() == 0)
        chk("unexpected_done", 1, 0);
      else begin
        it = sb_q.pop_front();
        chk("bcd", o_bcd, it.bcd);
        chk("latency_edges", cyc - it.acc - 1, IN_W + 1);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!o_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!o_ready)
      chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [IN_W-1:0] v, input logic [11:0] e, input bit hold);
    i_cnt = v;
    exp_cur = e;
    i_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    if (!hold)
      i_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (n_done < target && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", int'(n_done >= target), 1);
  endtask

  task automatic scan_chk(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
    logic [2:0] prev;
    logic [6:0] segs [3];
    logic [2:0] coms [3];
    int k;
    segs = '{s0, s1, s2};
    coms = '{3'b110, 3'b101, 3'b011};
    prev = o_fnd_com;
    @(negedge clk);
    k = 0;
    while (!(o_fnd_com == 3'b110 && prev != 3'b110) && k < 20) begin
      prev = o_fnd_com;
      @(negedge clk);
      k++;
    end
    chk("scan_sync", int'(k < 20), 1);
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 3; d++)
        for (int c = 0; c < 4; c++) begin
          chk("scan_com_seg", {o_fnd_com, o_fnd_seg}, {coms[d], segs[d]});
          @(negedge clk);
        end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int d0;
    int lo;
    repeat (2) @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_done", o_done, 0);
    chk("rst_bcd", o_bcd, 12'h000);
    chk("rst_com", o_fnd_com, 3'b110);
    chk("rst_seg", o_fnd_seg, 7'h40);
    reset = 1'b0;
    @(negedge clk);

    d0 = n_done;
    send(7'd100, 12'h100, 1'b0);
    lo = 0;
    while (!o_ready && lo < 20) begin
      lo++;
      @(negedge clk);
    end
    chk("ready_low_cycles", lo, IN_W + 1);
    chk("done_pulse", o_done, 1);
    @(negedge clk);
    chk("done_clear", o_done, 0);
    chk("done_count_100", n_done - d0, 1);

    d0 = n_done;
    send(7'd0, 12'h000, 1'b1);
    chk_sp = 1'b1;
    send(7'd99, 12'h099, 1'b1);
    send(7'd127, 12'h127, 1'b1);
    i_valid = 1'b0;
    chk_sp = 1'b0;
    wait_done(d0 + 3);
    chk("done_count_seq", n_done - d0, 3);

    d0 = n_done;
    send(7'd55, 12'h055, 1'b0);
    @(negedge clk);
    i_cnt = 7'd77;
    exp_cur = 12'h077;
    i_valid = 1'b1;
    chk("busy_ready", o_ready, 0);
    @(negedge clk);
    i_valid = 1'b0;
    wait_done(d0 + 1);
    repeat (12) @(negedge clk);
    chk("busy_done_count", n_done - d0, 1);
    chk("busy_bcd", o_bcd, 12'h055);

    d0 = n_done;
    send(7'd42, 12'h042, 1'b0);
    wait_done(d0 + 1);
    scan_chk(7'h24, 7'h19, 7'h7F);

    d0 = n_done;
    send(7'd105, 12'h105, 1'b0);
    wait_done(d0 + 1);
    scan_chk(7'h12, 7'h40, 7'h79);

    d0 = n_done;
    send(7'd88, 12'h088, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    sb_q.delete();
    #1;
    chk("async_rst_bcd", o_bcd, 12'h000);
    chk("async_rst_done", o_done, 0);
    chk("async_rst_ready", o_ready, 1);
    chk("async_rst_com", o_fnd_com, 3'b110);
    chk("async_rst_seg", o_fnd_seg, 7'h40);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_bcd", o_bcd, 12'h000);

    d0 = n_done;
    send(7'd88, 12'h088, 1'b0);
    wait_done(d0 + 1);
    scan_chk(7'h00, 7'h00, 7'h7F);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("done_total", n_done, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
